// File: rtl/approx_mult_err_monitor.sv
// Accuracy monitor for approximate multipliers: recomputes a*b, and accumulates error count,
// ED sum (saturating) and max ED with its operands over a run of num_samples samples.
module approx_mult_err_monitor #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 17,
   parameter int unsigned ACC_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CNT_W-1:0]     num_samples,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic [2*WIDTH-1:0]   in_r,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [CNT_W-1:0]     res_count,
   output logic [CNT_W-1:0]     res_err_cnt,
   output logic [ACC_W-1:0]     res_sum_ed,
   output logic [2*WIDTH-1:0]   res_max_ed,
   output logic [WIDTH-1:0]     res_max_a,
   output logic [WIDTH-1:0]     res_max_b,
   output logic                 busy,
   output logic                 ovf
);

   localparam int unsigned PW = 2 * WIDTH;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   nsamp_q;
   logic [CNT_W-1:0]   accepted_q;
   logic               drain_q;

   logic               s1_valid_q;
   logic [WIDTH-1:0]   s1_a_q;
   logic [WIDTH-1:0]   s1_b_q;
   logic [PW-1:0]      s1_r_q;

   logic               s2_valid_q;
   logic [PW-1:0]      s2_ed_q;
   logic [WIDTH-1:0]   s2_a_q;
   logic [WIDTH-1:0]   s2_b_q;

   logic               accept;
   logic [PW-1:0]      exact;
   logic [PW:0]        diff;
   logic [PW:0]        ndiff;
   logic [PW-1:0]      ed;
   logic [ACC_W:0]     sum_ext;

   assign in_ready  = (state_q == StRun) && (accepted_q < nsamp_q);
   assign accept    = in_valid & in_ready;
   assign res_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);

   // Difference is taken one bit wider so r > a*b yields a correct magnitude.
   always_comb begin
      exact   = PW'(s1_a_q) * PW'(s1_b_q);
      diff    = {1'b0, exact} - {1'b0, s1_r_q};
      ndiff   = -diff;
      ed      = diff[PW] ? ndiff[PW-1:0] : diff[PW-1:0];
      sum_ext = {1'b0, res_sum_ed} + (ACC_W+1)'(s2_ed_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         nsamp_q     <= '0;
         accepted_q  <= '0;
         drain_q     <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_r_q      <= '0;
         s2_valid_q  <= 1'b0;
         s2_ed_q     <= '0;
         s2_a_q      <= '0;
         s2_b_q      <= '0;
         res_count   <= '0;
         res_err_cnt <= '0;
         res_sum_ed  <= '0;
         res_max_ed  <= '0;
         res_max_a   <= '0;
         res_max_b   <= '0;
         ovf         <= 1'b0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_a_q <= in_a;
            s1_b_q <= in_b;
            s1_r_q <= in_r;
         end
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_ed_q <= ed;
            s2_a_q  <= s1_a_q;
            s2_b_q  <= s1_b_q;
         end
         if (s2_valid_q) begin
            res_count <= res_count + 1'b1;
            if (s2_ed_q != '0) res_err_cnt <= res_err_cnt + 1'b1;
            if (sum_ext[ACC_W]) begin
               res_sum_ed <= '1;
               ovf        <= 1'b1;
            end else begin
               res_sum_ed <= sum_ext[ACC_W-1:0];
            end
            // Strict compare: ties keep the first sample, ED=0 never updates.
            if (s2_ed_q > res_max_ed) begin
               res_max_ed <= s2_ed_q;
               res_max_a  <= s2_a_q;
               res_max_b  <= s2_b_q;
            end
         end

         unique case (state_q)
            StIdle: begin
               if (start) begin
                  nsamp_q     <= num_samples;
                  accepted_q  <= '0;
                  res_count   <= '0;
                  res_err_cnt <= '0;
                  res_sum_ed  <= '0;
                  res_max_ed  <= '0;
                  res_max_a   <= '0;
                  res_max_b   <= '0;
                  ovf         <= 1'b0;
                  state_q     <= (num_samples == '0) ? StDone : StRun;
               end
            end
            StRun: begin
               if (accept) begin
                  accepted_q <= accepted_q + 1'b1;
                  if (accepted_q + 1'b1 == nsamp_q) begin
                     state_q <= StDrain;
                     drain_q <= 1'b0;
                  end
               end
            end
            StDrain: begin
               drain_q <= 1'b1;
               if (drain_q) state_q <= StDone;
            end
            StDone: begin
               if (res_ready) state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed bench for approx_mult_err_monitor; a second instance with ACC_W=16 shares all inputs
// so saturation can be observed within a few samples.
module tb_approx_mult_err_monitor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [16:0] num_samples = '0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic [15:0] in_r = '0;
   logic        res_ready = 1'b0;

   logic        in_ready, res_valid, busy, ovf;
   logic [16:0] res_count, res_err_cnt;
   logic [31:0] res_sum_ed;
   logic [15:0] res_max_ed;
   logic [7:0]  res_max_a, res_max_b;

   logic        s_in_ready, s_res_valid, s_busy, s_ovf;
   logic [16:0] s_res_count, s_res_err_cnt;
   logic [15:0] s_res_sum_ed;
   logic [15:0] s_res_max_ed;
   logic [7:0]  s_res_max_a, s_res_max_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   approx_mult_err_monitor #(.WIDTH(8), .CNT_W(17), .ACC_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_r(in_r),
      .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
      .res_err_cnt(res_err_cnt), .res_sum_ed(res_sum_ed), .res_max_ed(res_max_ed),
      .res_max_a(res_max_a), .res_max_b(res_max_b), .busy(busy), .ovf(ovf)
   );

   approx_mult_err_monitor #(.WIDTH(8), .CNT_W(17), .ACC_W(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b), .in_r(in_r),
      .res_valid(s_res_valid), .res_ready(res_ready), .res_count(s_res_count),
      .res_err_cnt(s_res_err_cnt), .res_sum_ed(s_res_sum_ed), .res_max_ed(s_res_max_ed),
      .res_max_a(s_res_max_a), .res_max_b(s_res_max_b), .busy(s_busy), .ovf(s_ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // num_samples is scrambled after the start edge; the latched value must be used.
   task automatic run_start(input logic [16:0] n);
      start = 1'b1;
      num_samples = n;
      tick();
      start = 1'b0;
      num_samples = 17'h1ffff;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
      int k;
      in_a = a;
      in_b = b;
      in_r = r;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 20) begin
         tick();
         k++;
      end
      if (!in_ready) begin
         errors++;
         $display("FAIL send_timeout in_ready=%0d required 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!res_valid && cyc < 50) begin
         tick();
         cyc++;
      end
   endtask

   task automatic finish_run();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++;
      if ({busy, res_valid, in_ready, ovf, s_busy, s_in_ready} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got %b required 000000",
                  {busy, res_valid, in_ready, ovf, s_busy, s_in_ready});
      end
      checks++;
      if ({res_count, res_err_cnt, res_sum_ed, res_max_ed, res_max_a, res_max_b} !== '0) begin
         errors++;
         $display("FAIL reset_results count=%0d sum=%0d max=%0d required 0",
                  res_count, res_sum_ed, res_max_ed);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_exact();
      int cyc;
      run_start(17'd4);
      send(8'd3, 8'd5, 16'd15);
      send(8'd255, 8'd255, 16'd65025);
      send(8'd0, 8'd77, 16'd0);
      send(8'd128, 8'd2, 16'd256);
      wait_done(cyc);
      checks++;
      if (cyc !== 2) begin
         errors++;
         $display("FAIL exact_drain_latency got %0d required 2", cyc);
      end
      checks++;
      if (res_count !== 17'd4 || res_err_cnt !== 17'd0) begin
         errors++;
         $display("FAIL exact_counts count=%0d err=%0d required 4 0", res_count, res_err_cnt);
      end
      checks++;
      if (res_sum_ed !== 32'd0 || res_max_ed !== 16'd0 || res_max_a !== 8'd0) begin
         errors++;
         $display("FAIL exact_stats sum=%0d max=%0d a=%0d required 0 0 0",
                  res_sum_ed, res_max_ed, res_max_a);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL exact_done_in_ready got %0d required 0", in_ready);
      end
      finish_run();
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL exact_idle busy=%0d res_valid=%0d required 0 0", busy, res_valid);
      end
   endtask

   task automatic test_single_error();
      int cyc;
      run_start(17'd4);
      send(8'd1, 8'd2, 16'd2);
      send(8'd255, 8'd255, 16'd65000);
      send(8'd3, 8'd4, 16'd12);
      send(8'd10, 8'd10, 16'd100);
      wait_done(cyc);
      checks++;
      if (res_err_cnt !== 17'd1 || res_sum_ed !== 32'd25 || res_count !== 17'd4) begin
         errors++;
         $display("FAIL single_err err=%0d sum=%0d count=%0d required 1 25 4",
                  res_err_cnt, res_sum_ed, res_count);
      end
      checks++;
      if (res_max_ed !== 16'd25 || res_max_a !== 8'd255 || res_max_b !== 8'd255) begin
         errors++;
         $display("FAIL single_max max=%0d a=%0d b=%0d required 25 255 255",
                  res_max_ed, res_max_a, res_max_b);
      end
      finish_run();
   endtask

   // Third sample has r > a*b (9-21), giving the same ED 12 as the second: tie keeps (2,2).
   task automatic test_tie_max();
      int cyc;
      run_start(17'd3);
      send(8'd1, 8'd1, 16'd8);
      send(8'd2, 8'd2, 16'd16);
      send(8'd3, 8'd3, 16'd21);
      wait_done(cyc);
      checks++;
      if (res_max_ed !== 16'd12 || res_max_a !== 8'd2 || res_max_b !== 8'd2) begin
         errors++;
         $display("FAIL tie_max max=%0d a=%0d b=%0d required 12 2 2",
                  res_max_ed, res_max_a, res_max_b);
      end
      checks++;
      if (res_sum_ed !== 32'd31 || res_err_cnt !== 17'd3) begin
         errors++;
         $display("FAIL tie_sum sum=%0d err=%0d required 31 3", res_sum_ed, res_err_cnt);
      end
      finish_run();
   endtask

   task automatic test_backpressure();
      int cyc;
      logic [7:0]  va [5] = '{8'd5, 8'd6, 8'd9, 8'd200, 8'd16};
      logic [7:0]  vb [5] = '{8'd5, 8'd7, 8'd9, 8'd100, 8'd16};
      logic [15:0] vr [5] = '{16'd20, 16'd42, 16'd90, 16'd20000, 16'd300};
      run_start(17'd5);
      for (int i = 0; i < 5; i++) begin
         send(va[i], vb[i], vr[i]);
         repeat ($urandom_range(0, 3)) tick();
      end
      wait_done(cyc);
      checks++;
      if (res_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_done_timeout res_valid=%0d required 1", res_valid);
      end
      for (int i = 0; i < 10; i++) begin
         start = (i == 3);
         num_samples = 17'd3;
         tick();
         checks++;
         if (res_valid !== 1'b1 || res_sum_ed !== 32'd58 || res_count !== 17'd5 ||
             res_err_cnt !== 17'd3 || res_max_ed !== 16'd44 || res_max_a !== 8'd16) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d valid=%0d sum=%0d count=%0d err=%0d max=%0d a=%0d required 1 58 5 3 44 16",
                     i, res_valid, res_sum_ed, res_count, res_err_cnt, res_max_ed, res_max_a);
         end
      end
      start = 1'b0;
      finish_run();
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || res_sum_ed !== 32'd58) begin
         errors++;
         $display("FAIL bp_idle busy=%0d valid=%0d sum=%0d required 0 0 58",
                  busy, res_valid, res_sum_ed);
      end
      in_valid = 1'b1;
      tick();
      tick();
      checks++;
      if (in_ready !== 1'b0 || res_count !== 17'd5) begin
         errors++;
         $display("FAIL bp_idle_input in_ready=%0d count=%0d required 0 5", in_ready, res_count);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_zero_samples();
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL zero_pre_in_ready got %0d required 0", in_ready);
      end
      in_valid = 1'b1;
      run_start(17'd0);
      checks++;
      if (res_valid !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL zero_done res_valid=%0d in_ready=%0d required 1 0", res_valid, in_ready);
      end
      checks++;
      if ({res_count, res_err_cnt, res_sum_ed, res_max_ed, res_max_a, res_max_b} !== '0) begin
         errors++;
         $display("FAIL zero_results count=%0d sum=%0d max=%0d required 0", res_count,
                  res_sum_ed, res_max_ed);
      end
      finish_run();
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b0 || res_count !== 17'd0) begin
         errors++;
         $display("FAIL zero_idle busy=%0d count=%0d required 0 0", busy, res_count);
      end
   endtask

   task automatic test_saturation();
      int cyc;
      run_start(17'd3);
      repeat (3) send(8'd0, 8'd0, 16'd30000);
      wait_done(cyc);
      checks++;
      if (s_res_valid !== 1'b1 || s_res_sum_ed !== 16'd65535 || s_ovf !== 1'b1) begin
         errors++;
         $display("FAIL sat16 valid=%0d sum=%0d ovf=%0d required 1 65535 1",
                  s_res_valid, s_res_sum_ed, s_ovf);
      end
      checks++;
      if (s_res_count !== 17'd3 || s_res_err_cnt !== 17'd3 || s_res_max_ed !== 16'd30000 ||
          s_res_max_a !== 8'd0 || s_res_max_b !== 8'd0) begin
         errors++;
         $display("FAIL sat16_stats count=%0d err=%0d max=%0d required 3 3 30000",
                  s_res_count, s_res_err_cnt, s_res_max_ed);
      end
      checks++;
      if (res_sum_ed !== 32'd90000 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL sat32 sum=%0d ovf=%0d required 90000 0", res_sum_ed, ovf);
      end
      finish_run();
   endtask

   task automatic test_reset_mid_run();
      int cyc;
      run_start(17'd4);
      send(8'd1, 8'd1, 16'd3);
      send(8'd2, 8'd2, 16'd0);
      tick();
      tick();
      checks++;
      if (res_count !== 17'd2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midrun_pre count=%0d busy=%0d required 2 1", res_count, busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, in_ready, res_valid, ovf, s_busy, s_ovf} !== 6'b0 ||
          {res_count, res_err_cnt, res_sum_ed, res_max_ed, res_max_a, res_max_b} !== '0) begin
         errors++;
         $display("FAIL midrun_reset busy=%0d count=%0d sum=%0d max=%0d required all 0",
                  busy, res_count, res_sum_ed, res_max_ed);
      end
      tick();
      rst_n = 1'b1;
      tick();
      run_start(17'd2);
      send(8'd7, 8'd8, 16'd56);
      send(8'd9, 8'd9, 16'd80);
      wait_done(cyc);
      checks++;
      if (res_count !== 17'd2 || res_err_cnt !== 17'd1 || res_sum_ed !== 32'd1 ||
          res_max_ed !== 16'd1 || res_max_a !== 8'd9 || res_max_b !== 8'd9) begin
         errors++;
         $display("FAIL midrun_newrun count=%0d err=%0d sum=%0d max=%0d a=%0d b=%0d required 2 1 1 1 9 9",
                  res_count, res_err_cnt, res_sum_ed, res_max_ed, res_max_a, res_max_b);
      end
      finish_run();
   endtask

   initial begin
      test_reset();
      test_exact();
      test_single_error();
      test_tie_max();
      test_backpressure();
      test_zero_samples();
      test_saturation();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
